// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: memory-stage instruction in, register-file write port out.
// Latency: none (wires only); the stage behind the slave modport adds one cycle.
// Backpressure: none; one instruction per cycle is always accepted.
interface writeback_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int CNT_WIDTH     = 64
);
  localparam int RW = $clog2(NUM_REGISTERS);

  // Memory-stage side
  logic                  mem_valid;
  logic                  mem_flush;
  logic                  mem_reg_write;
  logic                  mem_is_load;
  logic [2:0]            mem_funct3;
  logic [RW-1:0]         mem_rd;
  logic [DATA_WIDTH-1:0] mem_result;
  logic [DATA_WIDTH-1:0] mem_load_data;

  // Register-file write port and retirement status
  logic                  write;
  logic [RW-1:0]         reg_wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  misalign_err;
  logic [CNT_WIDTH-1:0]  instret;

  // Upstream pipeline / environment view
  modport master (
    output mem_valid, mem_flush, mem_reg_write, mem_is_load, mem_funct3,
           mem_rd, mem_result, mem_load_data,
    input  write, reg_wr, data_in, misalign_err, instret
  );

  // Writeback stage view
  modport slave (
    input  mem_valid, mem_flush, mem_reg_write, mem_is_load, mem_funct3,
           mem_rd, mem_result, mem_load_data,
    output write, reg_wr, data_in, misalign_err, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB stage: load alignment/extension, fault and x0 write suppression, retire counter.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; accepts one instruction every cycle indefinitely.
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int CNT_WIDTH     = 64
) (
  input  logic               clk,
  input  logic               rst,
  writeback_stage_if.slave   wb
);
  localparam int RW = $clog2(NUM_REGISTERS);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic                  take;
  logic [1:0]            off;
  logic [4:0]            shamt;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic                  fault;
  logic [DATA_WIDTH-1:0] wdata;

  logic                  write_q;
  logic [RW-1:0]         reg_wr_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic                  misalign_q;
  logic [CNT_WIDTH-1:0]  instret_q;

  // Decode the slot: lane selection, load extension and fault detection
  always_comb begin
    take   = wb.mem_valid & ~wb.mem_flush;
    off    = wb.mem_result[1:0];
    shamt  = {off, 3'b000};
    // Lanes are little-endian, so shifting right by 8*off brings the addressed byte/half to bit 0
    byte_v = 8'(wb.mem_load_data >> shamt);
    half_v = 16'(wb.mem_load_data >> shamt);
    fault  = 1'b0;
    wdata  = wb.mem_result;
    if (wb.mem_is_load) begin
      case (wb.mem_funct3)
        F3_LB:  wdata = DATA_WIDTH'($signed(byte_v));
        F3_LBU: wdata = DATA_WIDTH'(byte_v);
        F3_LH: begin
          fault = off[0];
          wdata = DATA_WIDTH'($signed(half_v));
        end
        F3_LHU: begin
          fault = off[0];
          wdata = DATA_WIDTH'(half_v);
        end
        F3_LW: begin
          fault = (off != 2'b00);
          wdata = DATA_WIDTH'($signed(wb.mem_load_data[31:0]));
        end
        default: fault = 1'b1;
      endcase
    end
  end

  // Register the write port, fault pulse and retirement count; bubbles clear write/fault
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q    <= 1'b0;
      reg_wr_q   <= '0;
      data_in_q  <= '0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      // x0 is never written: the register file forwards data_in on address match
      write_q    <= take & wb.mem_reg_write & (wb.mem_rd != '0) & ~fault;
      reg_wr_q   <= wb.mem_rd;
      data_in_q  <= wdata;
      misalign_q <= take & fault;
      if (take & ~fault) begin
        instret_q <= instret_q + CNT_WIDTH'(1);
      end
    end
  end

  assign wb.write        = write_q;
  assign wb.reg_wr       = reg_wr_q;
  assign wb.data_in      = data_in_q;
  assign wb.misalign_err = misalign_q;
  assign wb.instret      = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases then random traffic.
// Latency: checks each slot 1 cycle after it is presented.
// Backpressure: none exercised; stage never stalls.
module tb_writeback_stage;
  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int CNT_W = 8;   // narrow counter so wrap-around is reachable
  localparam longint unsigned CNT_MOD = 64'd1 << CNT_W;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  longint unsigned exp_instret;

  writeback_stage_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .CNT_WIDTH(CNT_W)) wb ();

  writeback_stage #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .CNT_WIDTH(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference load semantics using plain integer arithmetic
  function automatic void ref_load(input logic isl, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] ld,
                                   output logic [31:0] val, output logic flt);
    int unsigned o, b, h;
    o   = addr % 4;
    b   = (ld >> (8 * o)) % 256;
    h   = (ld >> (8 * o)) % 65536;
    val = addr;
    flt = 1'b0;
    if (isl) begin
      if (f3 == 3'd0)      val = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      else if (f3 == 3'd4) val = b;
      else if (f3 == 3'd1 || f3 == 3'd5) begin
        if (o % 2 == 1) flt = 1'b1;
        else val = (f3 == 3'd1 && h >= 32768) ? h + 32'hFFFF_0000 : h;
      end else if (f3 == 3'd2) begin
        if (o != 0) flt = 1'b1;
        else val = ld;
      end else flt = 1'b1;
    end
  endfunction

  task automatic drive(input logic v, input logic fl, input logic rw, input logic isl,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] ld);
    wb.mem_valid     = v;
    wb.mem_flush     = fl;
    wb.mem_reg_write = rw;
    wb.mem_is_load   = isl;
    wb.mem_funct3    = f3;
    wb.mem_rd        = rd;
    wb.mem_result    = res;
    wb.mem_load_data = ld;
  endtask

  // Present one slot, advance one edge, compare against the model
  task automatic step(input string tag, input logic v, input logic fl, input logic rw,
                      input logic isl, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] res, input logic [31:0] ld);
    logic [31:0] ev;
    logic        ef, tk, ew;
    @(negedge clk);
    drive(v, fl, rw, isl, f3, rd, res, ld);
    ref_load(isl, f3, res, ld, ev, ef);
    tk = v & ~fl;
    ew = tk & rw & (rd != 5'd0) & ~ef;
    if (tk && !ef) exp_instret = (exp_instret + 1) % CNT_MOD;
    @(posedge clk);
    #1;
    check({tag, ".write"}, 64'(wb.write), 64'(ew));
    check({tag, ".misalign"}, 64'(wb.misalign_err), 64'(tk & ef));
    check({tag, ".instret"}, 64'(wb.instret), exp_instret);
    if (ew) begin
      check({tag, ".reg_wr"}, 64'(wb.reg_wr), 64'(rd));
      check({tag, ".data_in"}, 64'(wb.data_in), 64'(ev));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".write"}, 64'(wb.write), 64'd0);
    check({tag, ".reg_wr"}, 64'(wb.reg_wr), 64'd0);
    check({tag, ".data_in"}, 64'(wb.data_in), 64'd0);
    check({tag, ".misalign"}, 64'(wb.misalign_err), 64'd0);
    check({tag, ".instret"}, 64'(wb.instret), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_instret = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ALU op
    step("alu",   1, 0, 1, 0, 3'd0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    check("alu.exact_data", 64'(wb.data_in), 64'hDEAD_BEEF);
    check("alu.exact_cnt", 64'(wb.instret), 64'd1);

    // Loads of 0x80FF7F01
    step("lb2",   1, 0, 1, 1, 3'd0, 5'd6, 32'h1000_0002, 32'h80FF_7F01);
    check("lb2.exact", 64'(wb.data_in), 64'hFFFF_FFFF);
    step("lbu3",  1, 0, 1, 1, 3'd4, 5'd7, 32'h1000_0003, 32'h80FF_7F01);
    check("lbu3.exact", 64'(wb.data_in), 64'h0000_0080);
    step("lh2",   1, 0, 1, 1, 3'd1, 5'd8, 32'h1000_0002, 32'h80FF_7F01);
    check("lh2.exact", 64'(wb.data_in), 64'hFFFF_80FF);
    step("lhu0",  1, 0, 1, 1, 3'd5, 5'd9, 32'h1000_0000, 32'h80FF_7F01);
    check("lhu0.exact", 64'(wb.data_in), 64'h0000_7F01);
    step("lw0",   1, 0, 1, 1, 3'd2, 5'd10, 32'h1000_0000, 32'h80FF_7F01);
    check("lw0.exact", 64'(wb.data_in), 64'h80FF_7F01);

    // Three consecutive faults
    step("lw1",   1, 0, 1, 1, 3'd2, 5'd11, 32'h1000_0001, 32'h80FF_7F01);
    step("lh3",   1, 0, 1, 1, 3'd1, 5'd12, 32'h1000_0003, 32'h80FF_7F01);
    step("f3_011", 1, 0, 1, 1, 3'd3, 5'd13, 32'h1000_0000, 32'h80FF_7F01);
    check("faults.exact_cnt", 64'(wb.instret), 64'd6);
    step("after_fault", 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);

    // x0 write and store
    step("rd0",   1, 0, 1, 0, 3'd0, 5'd0, 32'h0000_1234, 32'h0);
    step("store", 1, 0, 0, 0, 3'd2, 5'd3, 32'h2000_0000, 32'h0);
    check("store.exact_cnt", 64'(wb.instret), 64'd8);

    // Flush beats valid
    step("flush", 1, 1, 1, 0, 3'd0, 5'd4, 32'h5555_5555, 32'h0);

    // Reset mid-stream with a pending write
    step("pre_rst", 1, 0, 1, 0, 3'd0, 5'd14, 32'hCAFE_F00D, 32'h0);
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    exp_instret = 0;
    @(negedge clk);
    drive(1, 0, 1, 0, 3'd0, 5'd15, 32'h1111_1111, 32'h0);
    @(posedge clk);
    #1 check_zero("inrst");
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("release.write", 64'(wb.write), 64'd0);
    check("release.instret", 64'(wb.instret), 64'd0);
    step("post_rst", 1, 0, 1, 0, 3'd0, 5'd16, 32'h2222_2222, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(3) != 0), ($urandom_range(7) == 0), 1'($urandom),
           1'($urandom), 3'($urandom), 5'($urandom), $urandom, $urandom);
    end

    // Counter wrap
    for (int i = 0; i < 300 && exp_instret != CNT_MOD - 1; i++) begin
      step("fill", 1, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
    end
    check("wrap.at_max", 64'(wb.instret), CNT_MOD - 1);
    step("wrap", 1, 0, 1, 0, 3'd0, 5'd1, 32'h0BAD_CAFE, 32'h0);
    check("wrap.zero", 64'(wb.instret), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
